// File: rtl/alu32_bist_pkg.sv
// alu_pkg: ALU32 control encodings, BIST FSM state codes, LFSR polynomial
// and the fixed opcode sequence walked by the self-test. Shared with ALU32
// and the ALU control decoder so every block agrees on ALUctl values.
package alu_pkg;

  // ALUctl encodings understood by ALU32
  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;

  // BIST FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Right-shifting Galois taps for x^32+x^22+x^2+x+1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // Number of opcodes in the self-test sequence
  localparam int N_OPS = 5;
  localparam logic [2:0] LAST_OP = 3'd4;

  // Opcode visited at each position of the self-test sequence
  function automatic logic [3:0] op_seq(input logic [2:0] idx);
    logic [3:0] op;
    case (idx)
      3'd0:    op = ALU_AND;
      3'd1:    op = ALU_OR;
      3'd2:    op = ALU_ADD;
      3'd3:    op = ALU_SUB;
      3'd4:    op = ALU_SLT;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu32_bist_if.sv
// ALU32 operand/control interface. The BIST (or datapath) is the master that
// drives ALUctl and the operands; ALU32 is the slave returning result and Zero.
interface alu32_bist_if;
  logic [3:0]  alu_ctl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_out;
  logic        alu_zero;

  modport master (output alu_ctl, alu_a, alu_b, input alu_out, alu_zero);
  modport slave  (input alu_ctl, alu_a, alu_b, output alu_out, alu_zero);
endinterface

// File: rtl/alu32_bist_lfsr32.sv
// lfsr32: 32-bit Galois LFSR used as an operand generator for the ALU BIST.
// Resets to RESET_VAL, reloads from seed on load, advances one step on step.
// load wins over step so a restart always begins from the seed.
module lfsr32
  import alu_pkg::*;
#(
  parameter logic [31:0] RESET_VAL = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] q
);

  // Seed reload has priority; otherwise shift right and fold in the taps when a one falls out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= seed;
    end else if (step) begin
      q <= {1'b0, q[31:1]} ^ (q[0] ? LFSR_POLY : 32'h0);
    end
  end

endmodule

// File: rtl/alu32_bist.sv
// alu32_bist: self-test initiator for ALU32. Walks AND, OR, ADD, SUB, SLT with
// N_VEC vectors each (vector 0 all-zero, the rest from two LFSRs), compares
// ALU32's result and Zero flag against a golden model and counts bad vectors.
// Optional feature: define ALU32_BIST_MISR_EN to compact every ALU result into
// a 32-bit MISR on signature; without it signature is tied to zero.
module alu32_bist
  import alu_pkg::*;
#(
  parameter int          N_VEC  = 4,
  parameter logic [31:0] SEED_A = 32'h1ACE_B00C,
  parameter logic [31:0] SEED_B = 32'h0BAD_F00D
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [7:0]         err_count,
  output logic [31:0]        signature,
  alu32_bist_if.master       alu
);

  localparam int VW = (N_VEC > 1) ? $clog2(N_VEC) : 1;
  localparam logic [VW-1:0] LAST_VEC = VW'(N_VEC - 1);

  logic [1:0]    state;
  logic [2:0]    op_idx;
  logic [VW-1:0] vec_idx;
  logic [31:0]   lfsr_a_q;
  logic [31:0]   lfsr_b_q;
  logic [31:0]   exp_out;
  logic          mismatch;
  logic          accept;
  logic          in_check;

  assign accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign in_check = (state == ST_CHECK);

  assign busy = (state == ST_DRIVE) || (state == ST_CHECK);
  assign done = (state == ST_DONE);
  assign pass = done && (err_count == 8'h00);

  lfsr32 #(.RESET_VAL(SEED_A)) u_lfsr_a (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .seed  (SEED_A),
    .step  (in_check),
    .q     (lfsr_a_q)
  );

  lfsr32 #(.RESET_VAL(SEED_B)) u_lfsr_b (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .seed  (SEED_B),
    .step  (in_check),
    .q     (lfsr_b_q)
  );

  // Golden model of ALU32 evaluated on the operands currently being driven
  always_comb begin
    exp_out = 32'h0;
    case (alu.alu_ctl)
      ALU_AND: exp_out = alu.alu_a & alu.alu_b;
      ALU_OR:  exp_out = alu.alu_a | alu.alu_b;
      ALU_ADD: exp_out = alu.alu_a + alu.alu_b;
      ALU_SUB: exp_out = alu.alu_a - alu.alu_b;
      ALU_SLT: exp_out = {31'b0, $signed(alu.alu_a) < $signed(alu.alu_b)};
      default: exp_out = 32'h0;
    endcase
  end

  // A vector is bad if either the result or the Zero flag disagrees with the model
  always_comb begin
    mismatch = (alu.alu_out != exp_out) || (alu.alu_zero != (exp_out == 32'h0));
  end

  // Sequencer: drive a vector, check it on the next cycle, step through vectors and opcodes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      op_idx      <= 3'd0;
      vec_idx     <= '0;
      alu.alu_ctl <= 4'd0;
      alu.alu_a   <= 32'h0;
      alu.alu_b   <= 32'h0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state   <= ST_DRIVE;
            op_idx  <= 3'd0;
            vec_idx <= '0;
          end
        end
        ST_DRIVE: begin
          alu.alu_ctl <= op_seq(op_idx);
          alu.alu_a   <= (vec_idx == '0) ? 32'h0 : lfsr_a_q;
          alu.alu_b   <= (vec_idx == '0) ? 32'h0 : lfsr_b_q;
          state       <= ST_CHECK;
        end
        ST_CHECK: begin
          if (vec_idx == LAST_VEC) begin
            vec_idx <= '0;
            if (op_idx == LAST_OP) begin
              state <= ST_DONE;
            end else begin
              op_idx <= op_idx + 3'd1;
              state  <= ST_DRIVE;
            end
          end else begin
            vec_idx <= vec_idx + VW'(1);
            state   <= ST_DRIVE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Error counter: cleared on an accepted start, one count per bad vector, sticks at 8'hFF
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'h00;
    end else if (accept) begin
      err_count <= 8'h00;
    end else if (in_check && mismatch && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'h01;
    end
  end

`ifdef ALU32_BIST_MISR_EN
  // MISR compacts each checked ALU result; Zero is deliberately left out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signature <= 32'h0;
    end else if (accept) begin
      signature <= 32'h0;
    end else if (in_check) begin
      signature <= {signature[30:0],
                    signature[31] ^ signature[21] ^ signature[1] ^ signature[0]} ^ alu.alu_out;
    end
  end
`else
  assign signature = 32'h0;
`endif

endmodule

// File: tb/tb_alu32_bist.sv
// tb_alu32_bist: pairs alu32_bist with a behavioural ALU32 that can inject
// faults (Zero stuck low, inverted SUB, single-bit ADD error, all results
// inverted) and checks timing, error counts, restart, async abort and
// error-counter saturation against directed expectations.
module tb_alu32_bist;
  import alu_pkg::*;

  localparam int          NV  = 4;
  localparam int          NV2 = 60;
  localparam logic [31:0] SA  = 32'h1ACE_B00C;
  localparam logic [31:0] SB  = 32'h0BAD_F00D;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        start2 = 1'b0;
  logic        busy, done, pass;
  logic [7:0]  err_count;
  logic [31:0] signature;
  logic        busy2, done2, pass2;
  logic [7:0]  err_count2;
  logic [31:0] signature2;

  int checks = 0;
  int errors = 0;
  int faultMode = 0;

  alu32_bist_if bif ();
  alu32_bist_if bif2 ();

  alu32_bist #(.N_VEC(NV), .SEED_A(SA), .SEED_B(SB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .signature (signature),
    .alu       (bif.master)
  );

  alu32_bist #(.N_VEC(NV2), .SEED_A(SA), .SEED_B(SB)) dut_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start2),
    .busy      (busy2),
    .done      (done2),
    .pass      (pass2),
    .err_count (err_count2),
    .signature (signature2),
    .alu       (bif2.master)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] refLfsr(input logic [31:0] q);
    logic [31:0] n;
    n = q >> 1;
    if (q[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  function automatic logic [31:0] refAlu(input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
    case (ctl)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      4'd6:    return a - b;
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] faultyOut(input int fm, input logic [3:0] ctl, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = refAlu(ctl, a, b);
    if (fm == 2 && ctl == 4'd6) r = ~r;
    if (fm == 3 && ctl == 4'd2) r = r ^ 32'h1;
    if (fm == 4) r = ~r;
    return r;
  endfunction

  function automatic logic faultyZero(input int fm, input logic [31:0] r);
    return (fm == 1) ? 1'b0 : (r == 32'h0);
  endfunction

  assign bif.alu_out   = faultyOut(faultMode, bif.alu_ctl, bif.alu_a, bif.alu_b);
  assign bif.alu_zero  = faultyZero(faultMode, bif.alu_out);
  assign bif2.alu_out  = faultyOut(4, bif2.alu_ctl, bif2.alu_a, bif2.alu_b);
  assign bif2.alu_zero = faultyZero(4, bif2.alu_out);

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Expected error count and MISR value for one full run under a given fault
  task automatic predictRun(input int fm, input int nv, output int errs, output logic [31:0] sig);
    logic [3:0]  opList [5];
    logic [31:0] la, lb, a, b, e, o;
    logic        z;
    opList = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7};
    la = SA; lb = SB; errs = 0; sig = 32'h0;
    for (int op = 0; op < 5; op++) begin
      for (int v = 0; v < nv; v++) begin
        a = (v == 0) ? 32'h0 : la;
        b = (v == 0) ? 32'h0 : lb;
        e = refAlu(opList[op], a, b);
        o = faultyOut(fm, opList[op], a, b);
        z = faultyZero(fm, o);
        if ((o != e || z != (e == 32'h0)) && errs < 255) errs++;
        sig = {sig[30:0], sig[31] ^ sig[21] ^ sig[1] ^ sig[0]} ^ o;
        la = refLfsr(la);
        lb = refLfsr(lb);
      end
    end
  endtask

  // One-cycle start pulse; the edge it is sampled on is edge 0
  task automatic applyStimulus();
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic runAndCheck(input string tag, input int fm, input int expErrs, input bit pulseMid,
                             output logic [31:0] sigOut);
    int          pErrs;
    logic [31:0] pSig;
    faultMode = fm;
    predictRun(fm, NV, pErrs, pSig);
    applyStimulus();
    @(negedge clk);
    checkOutput({tag, " busy@0"}, busy, 1);
    checkOutput({tag, " done clr"}, done, 0);
    checkOutput({tag, " err clr"}, err_count, 0);
    for (int e = 1; e <= 2 * 5 * NV - 1; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 1) checkOutput({tag, " ctl v0"}, bif.alu_ctl, ALU_AND);
      if (e == 1) checkOutput({tag, " a v0"}, bif.alu_a, 32'h0);
      if (e == 3) checkOutput({tag, " a v1"}, bif.alu_a, refLfsr(SA));
      if (e == 3) checkOutput({tag, " b v1"}, bif.alu_b, refLfsr(SB));
      if (e == 2 * NV + 1) checkOutput({tag, " ctl OR"}, bif.alu_ctl, ALU_OR);
      if (pulseMid && e == 10) start = 1'b1;
      if (pulseMid && e == 11) start = 1'b0;
      if (e == 2 * 5 * NV - 1) checkOutput({tag, " busy last"}, busy, 1);
      if (e == 2 * 5 * NV - 1) checkOutput({tag, " done early"}, done, 0);
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput({tag, " busy end"}, busy, 0);
    checkOutput({tag, " done end"}, done, 1);
    checkOutput({tag, " err"}, err_count, expErrs);
    checkOutput({tag, " err model"}, err_count, pErrs);
    checkOutput({tag, " pass"}, pass, (expErrs == 0) ? 1 : 0);
`ifdef ALU32_BIST_MISR_EN
    checkOutput({tag, " sig"}, signature, pSig);
`else
    checkOutput({tag, " sig"}, signature, 32'h0);
`endif
    sigOut = signature;
  endtask

  initial begin
    logic [31:0] sigA, sigB, sigGood, sigAdd;
    int          pErrs;
    logic [31:0] pSig;
    bit          seen;

    #23;
    checkOutput("rst busy", busy, 0);
    checkOutput("rst done", done, 0);
    checkOutput("rst pass", pass, 0);
    checkOutput("rst err", err_count, 0);
    checkOutput("rst sig", signature, 0);
    checkOutput("rst ctl", bif.alu_ctl, 0);
    checkOutput("rst a", bif.alu_a, 0);
    checkOutput("rst b", bif.alu_b, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle busy", busy, 0);

    $display("[TB] good ALU");
    runAndCheck("good", 0, 0, 1'b0, sigGood);

    $display("[TB] Zero stuck low");
    predictRun(1, NV, pErrs, pSig);
    runAndCheck("zstuck", 1, pErrs, 1'b0, sigA);
    checkOutput("zstuck atleast5", (err_count >= 8'd5) ? 1 : 0, 1);

    $display("[TB] SUB inverted, then restart with busy-time start pulse");
    runAndCheck("subinv", 2, 4, 1'b0, sigA);
    runAndCheck("restart", 2, 4, 1'b1, sigB);
    checkOutput("restart sig", sigB, sigA);

    $display("[TB] ADD single-bit fault");
    runAndCheck("addbit", 3, 4, 1'b0, sigAdd);
`ifdef ALU32_BIST_MISR_EN
    checkOutput("addbit sig differs", (sigAdd != sigGood) ? 1 : 0, 1);
`endif

    $display("[TB] reset mid-test");
    faultMode = 0;
    applyStimulus();
    repeat (16) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort busy", busy, 0);
    checkOutput("abort done", done, 0);
    checkOutput("abort err", err_count, 0);
    checkOutput("abort ctl", bif.alu_ctl, 0);
    checkOutput("abort a", bif.alu_a, 0);
    checkOutput("abort b", bif.alu_b, 0);
    @(negedge clk) rst_n = 1'b1;
    runAndCheck("post abort", 0, 0, 1'b0, sigA);

    $display("[TB] error counter saturation");
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 2 * 5 * NV2 + 20; c++) begin
      @(negedge clk);
      if (done2) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("sat done", seen, 1);
    checkOutput("sat err", err_count2, 8'hFF);
    checkOutput("sat pass", pass2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
